cnu_serial: RTL and testbench

- Serial offset-min-sum Check Node Unit; the stage directly downstream of the VNU array, closing the decoding loop.
- Consumes the DEG 6-bit VNU→CNU messages of one check row, one per cycle.
- Returns DEG 5-bit sign-magnitude CNU→VNU messages, one per cycle.
- Also reports the parity check over the hard-decision bits carried in the VNU messages.

---
 rtl/cnu_if.sv | 24 ++
 rtl/cnu_serial.sv | 161 ++++++++++++++++
 tb/tb_cnu_serial.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnu_if.sv
// Handshake bundle between the VNU array and the serial check node unit.
interface cnu_if #(
  parameter int MAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [MAG_W+1:0] in_msg;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W:0]   out_msg;
  logic             out_last;
  logic             parity_valid;
  logic             parity_ok;

  modport master (
    output in_valid, in_msg, out_ready,
    input  in_ready, out_valid, out_msg, out_last, parity_valid, parity_ok
  );

  modport slave (
    input  in_valid, in_msg, out_ready,
    output in_ready, out_valid, out_msg, out_last, parity_valid, parity_ok
  );
endinterface

// File: rtl/cnu_serial.sv
// Serial offset-min-sum check node: accumulates one row of VNU messages, then
// replays per-edge extrinsic messages while the next row accumulates.
module cnu_serial #(
  parameter int DEG    = 6,
  parameter int MAG_W  = 4,
  parameter int OFFSET = 0
) (
  input  logic  clk,
  input  logic  rst,
  cnu_if.slave  bus
);
  localparam int CW = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [MAG_W-1:0] MAG_MAX = '1;
  localparam logic [CW-1:0]    LAST_IDX = CW'(DEG - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  // front end: running row statistics
  logic [CW-1:0]    cnt;
  logic [MAG_W-1:0] min1, min2;
  logic [CW-1:0]    idx1;
  logic             sp, hx;
  logic [DEG-1:0]   sgn;

  logic [MAG_W-1:0] in_mag;
  logic             in_sgn, in_hd;
  logic [MAG_W-1:0] n_min1, n_min2;
  logic [CW-1:0]    n_idx1;
  logic             n_sp, n_hx;
  logic [DEG-1:0]   n_sgn;
  logic             in_xfer, last_in, handoff;

  assign in_mag = bus.in_msg[MAG_W-1:0];
  assign in_sgn = bus.in_msg[MAG_W];
  assign in_hd  = bus.in_msg[MAG_W+1];

  // statistics including the message currently offered; the handoff copies
  // these directly so the snapshot never misses the row's last message
  always_comb begin
    n_min1 = min1;
    n_min2 = min2;
    n_idx1 = idx1;
    n_sp   = sp ^ in_sgn;
    n_hx   = hx ^ in_hd;
    n_sgn  = sgn;
    n_sgn[cnt] = in_sgn;
    if (in_mag < min1) begin
      n_min2 = min1;
      n_min1 = in_mag;
      n_idx1 = cnt;
    end else if (in_mag < min2) begin
      n_min2 = in_mag;
    end
  end

  assign in_xfer = bus.in_valid & bus.in_ready;
  assign last_in = (cnt == LAST_IDX);
  assign handoff = in_xfer & last_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      min1 <= MAG_MAX;
      min2 <= MAG_MAX;
      idx1 <= '0;
      sp   <= 1'b0;
      hx   <= 1'b0;
      sgn  <= '0;
    end else if (in_xfer) begin
      sgn <= n_sgn;
      if (last_in) begin
        cnt  <= '0;
        min1 <= MAG_MAX;
        min2 <= MAG_MAX;
        idx1 <= '0;
        sp   <= 1'b0;
        hx   <= 1'b0;
      end else begin
        cnt  <= cnt + CW'(1);
        min1 <= n_min1;
        min2 <= n_min2;
        idx1 <= n_idx1;
        sp   <= n_sp;
        hx   <= n_hx;
      end
    end
  end

  // back end: snapshot of the completed row and the emit sequencer
  state_t           state, state_d;
  logic [CW-1:0]    j;
  logic [MAG_W-1:0] b_min1, b_min2;
  logic [CW-1:0]    b_idx1;
  logic             b_sp;
  logic [DEG-1:0]   b_sgn;
  logic             par_vld, par_ok;

  logic             emit, out_xfer, last_out;
  logic [MAG_W-1:0] raw, mag;
  logic [MAG_W:0]   diff;
  logic             osgn;

  assign emit     = (state == EMIT);
  assign last_out = (j == LAST_IDX);
  assign out_xfer = emit & bus.out_ready;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (handoff) state_d = EMIT;
      EMIT: if (out_xfer && last_out && !handoff) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      j       <= '0;
      b_min1  <= '0;
      b_min2  <= '0;
      b_idx1  <= '0;
      b_sp    <= 1'b0;
      b_sgn   <= '0;
      par_vld <= 1'b0;
      par_ok  <= 1'b0;
    end else begin
      state   <= state_d;
      par_vld <= handoff;
      if (handoff) begin
        b_min1 <= n_min1;
        b_min2 <= n_min2;
        b_idx1 <= n_idx1;
        b_sp   <= n_sp;
        b_sgn  <= n_sgn;
        par_ok <= ~n_hx;
        j      <= '0;
      end else if (out_xfer) begin
        j <= last_out ? '0 : j + CW'(1);
      end
    end
  end

  // extrinsic magnitude excludes the edge's own contribution; a negative
  // difference shows up in the extra top bit and saturates to zero
  always_comb begin
    raw  = (j == b_idx1) ? b_min2 : b_min1;
    diff = {1'b0, raw} - (MAG_W+1)'(OFFSET);
    mag  = diff[MAG_W] ? '0 : diff[MAG_W-1:0];
    osgn = (b_sp ^ b_sgn[j]) & (mag != '0);
  end

  assign bus.out_valid    = emit;
  assign bus.out_msg      = emit ? {osgn, mag} : '0;
  assign bus.out_last     = emit & last_out;
  assign bus.parity_valid = par_vld;
  assign bus.parity_ok    = par_ok;
  // only the row-closing message can be held off, and only while the
  // snapshot is still being replayed
  assign bus.in_ready     = ~(last_in & emit & ~(out_xfer & last_out));
endmodule

// File: tb/tb_cnu_serial.sv
// Bench for cnu_serial: fixed row vectors plus randomized streams checked
// against a leave-one-out min/xor reference model.
module tb_cnu_serial;
  localparam int DEG = 6;
  localparam int MW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [MW+1:0] in_msg   = '0;
  logic          out_ready = 1'b0;

  cnu_if #(.MAG_W(MW)) if0 ();
  cnu_if #(.MAG_W(MW)) if4 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_msg    = in_msg;
  assign if0.out_ready = out_ready;
  assign if4.in_valid  = in_valid;
  assign if4.in_msg    = in_msg;
  assign if4.out_ready = out_ready;

  cnu_serial #(.DEG(DEG), .MAG_W(MW), .OFFSET(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  cnu_serial #(.DEG(DEG), .MAG_W(MW), .OFFSET(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // reference model state
  typedef struct { logic [4:0] m0; logic [4:0] m4; bit last; } exp_t;
  exp_t       outq[$];
  logic [5:0] row[$];
  bit         hand_pend = 0;
  bit         exp_pok   = 0;
  bit         mon_en    = 0;

  logic [4:0] cap0[$];
  logic [4:0] cap4[$];
  bit         caplast[$];
  bit         cappar[$];

  int cyc = 0, ocnt = 0, o_first = -1, o_lastc = -1, nwait = 0, pcnt = 0, rdy_mode = 0;
  bit st_pend = 0;
  logic [4:0] st_m0;
  bit st_l;

  function automatic logic [4:0] shape(input int m, input int off, input bit s);
    int v;
    v = (m > off) ? m - off : 0;
    return {(v != 0) & s, 4'(v)};
  endfunction

  // each edge gets min and sign-xor over every other edge in the row
  function automatic void model_row();
    bit hx;
    hx = 0;
    for (int k = 0; k < DEG; k++) begin
      int m; bit s; exp_t e;
      m = 15; s = 0;
      for (int i = 0; i < DEG; i++)
        if (i != k) begin
          if (int'(row[i][3:0]) < m) m = int'(row[i][3:0]);
          s ^= row[i][4];
        end
      e.m0 = shape(m, 0, s);
      e.m4 = shape(m, 4, s);
      e.last = (k == DEG - 1);
      outq.push_back(e);
      hx ^= row[k][5];
    end
    exp_pok = ~hx;
  endfunction

  always @(posedge clk) begin
    #1;
    pcnt++;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (pcnt % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin : mon
    bit ov_exp; bit rdy_exp; exp_t e;
    if (mon_en) begin
      cyc++;
      ov_exp  = outq.size() > 0;
      rdy_exp = !(row.size() == DEG - 1 && ov_exp && !(outq.size() == 1 && out_ready));
      chk("in_ready", int'(if0.in_ready), int'(rdy_exp));
      chk("in_ready_off4", int'(if4.in_ready), int'(rdy_exp));
      chk("out_valid", int'(if0.out_valid), int'(ov_exp));
      chk("out_valid_off4", int'(if4.out_valid), int'(ov_exp));
      if (hand_pend) begin
        chk("parity_valid", int'(if0.parity_valid), 1);
        chk("parity_ok", int'(if0.parity_ok), int'(exp_pok));
        cappar.push_back(if0.parity_ok);
        hand_pend = 0;
      end else begin
        chk("parity_valid_idle", int'(if0.parity_valid), 0);
      end
      if (st_pend && if0.out_valid) begin
        chk("stall_hold_msg", int'(if0.out_msg), int'(st_m0));
        chk("stall_hold_last", int'(if0.out_last), int'(st_l));
      end
      st_pend = if0.out_valid && !out_ready;
      st_m0   = if0.out_msg;
      st_l    = if0.out_last;
      if (if0.out_valid && out_ready && outq.size() > 0) begin
        e = outq.pop_front();
        chk("out_msg", int'(if0.out_msg), int'(e.m0));
        chk("out_msg_off4", int'(if4.out_msg), int'(e.m4));
        chk("out_last", int'(if0.out_last), int'(e.last));
        cap0.push_back(if0.out_msg);
        cap4.push_back(if4.out_msg);
        caplast.push_back(if0.out_last);
        ocnt++;
        if (o_first < 0) o_first = cyc;
        o_lastc = cyc;
      end
      if (in_valid && if0.in_ready) begin
        row.push_back(in_msg);
        if (row.size() == DEG) begin
          model_row();
          row.delete();
          hand_pend = 1;
        end
      end
    end
  end

  task automatic send(input logic [5:0] m);
    int g; bit acc;
    g = 0;
    in_valid = 1'b1;
    in_msg   = m;
    do begin
      @(negedge clk);
      acc = if0.in_ready;
      @(posedge clk);
      #1;
      if (!acc) nwait++;
      g++;
    end while (!acc && g < 500);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((outq.size() > 0 || hand_pend) && g < 400) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 400) chk("drain_timeout", 0, 1);
  endtask

  typedef logic [5:0][3:0] mag6_t;
  typedef struct packed {
    mag6_t mag; logic [5:0] sg; logic [5:0] hd;
    mag6_t em0; logic [5:0] es0; mag6_t em4; logic [5:0] es4; logic pok;
  } vec_t;

  function automatic mag6_t m6(input int a, b, c, d, e, f);
    mag6_t r;
    r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c); r[3] = 4'(d); r[4] = 4'(e); r[5] = 4'(f);
    return r;
  endfunction

  function automatic logic [5:0] b6(input bit a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  vec_t tbl[5];

  initial begin
    tbl[0] = '{mag: m6(9,3,7,12,5,15), sg: b6(0,1,0,0,1,0), hd: b6(1,0,1,1,0,1),
               em0: m6(3,5,3,3,3,3),   es0: b6(0,1,0,0,1,0),
               em4: m6(0,1,0,0,0,0),   es4: b6(0,1,0,0,0,0), pok: 1'b1};
    tbl[1] = '{mag: m6(4,4,8,8,8,8),   sg: b6(0,0,1,0,0,0), hd: b6(1,0,1,1,0,0),
               em0: m6(4,4,4,4,4,4),   es0: b6(1,1,0,1,1,1),
               em4: m6(0,0,0,0,0,0),   es4: b6(0,0,0,0,0,0), pok: 1'b0};
    tbl[2] = '{mag: m6(0,0,0,0,0,0),   sg: b6(1,0,0,0,0,0), hd: b6(0,0,0,0,0,0),
               em0: m6(0,0,0,0,0,0),   es0: b6(0,0,0,0,0,0),
               em4: m6(0,0,0,0,0,0),   es4: b6(0,0,0,0,0,0), pok: 1'b1};
    tbl[3] = '{mag: m6(15,15,15,15,15,15), sg: b6(1,1,1,1,1,1), hd: b6(1,1,1,1,1,1),
               em0: m6(15,15,15,15,15,15), es0: b6(1,1,1,1,1,1),
               em4: m6(11,11,11,11,11,11), es4: b6(1,1,1,1,1,1), pok: 1'b1};
    tbl[4] = '{mag: m6(7,6,1,9,2,10),  sg: b6(1,1,0,1,0,0), hd: b6(0,0,0,0,0,1),
               em0: m6(1,1,2,1,1,1),   es0: b6(0,0,1,0,1,1),
               em4: m6(0,0,0,0,0,0),   es4: b6(0,0,0,0,0,0), pok: 1'b0};

    // reset state
    @(negedge clk);
    chk("rst_in_ready", int'(if0.in_ready), 1);
    chk("rst_out_valid", int'(if0.out_valid), 0);
    chk("rst_out_msg", int'(if0.out_msg), 0);
    chk("rst_out_last", int'(if0.out_last), 0);
    chk("rst_parity_valid", int'(if0.parity_valid), 0);
    chk("rst_parity_ok", int'(if0.parity_ok), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;

    // reset in the middle of a row
    for (int i = 0; i < 3; i++) send(6'(i * 5 + 1));
    mon_en = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrow_rst_in_ready", int'(if0.in_ready), 1);
    chk("midrow_rst_out_valid", int'(if0.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    row.delete(); outq.delete(); hand_pend = 0; st_pend = 0;
    mon_en = 1;

    // fixed vectors
    for (int v = 0; v < 5; v++) begin
      int g;
      cap0.delete(); cap4.delete(); caplast.delete(); cappar.delete();
      for (int k = 0; k < DEG; k++) send({tbl[v].hd[k], tbl[v].sg[k], tbl[v].mag[k]});
      g = 0;
      while ((cap0.size() < DEG || cappar.size() < 1) && g < 40) begin
        @(posedge clk); #1; g++;
      end
      if (g >= 40) chk($sformatf("vec%0d_timeout", v), 0, 1);
      else begin
        for (int k = 0; k < DEG; k++) begin
          chk($sformatf("vec%0d_off0_%0d", v, k), int'(cap0[k]), int'({tbl[v].es0[k], tbl[v].em0[k]}));
          chk($sformatf("vec%0d_off4_%0d", v, k), int'(cap4[k]), int'({tbl[v].es4[k], tbl[v].em4[k]}));
          chk($sformatf("vec%0d_last_%0d", v, k), int'(caplast[k]), int'(k == DEG - 1));
        end
        chk($sformatf("vec%0d_parity", v), int'(cappar[0]), int'(tbl[v].pok));
      end
    end

    // throughput: four rows back-to-back with no output stall
    drain();
    rdy_mode = 0; @(posedge clk); #1;
    nwait = 0; ocnt = 0; o_first = -1;
    for (int i = 0; i < 4 * DEG; i++) send(6'($urandom_range(0, 63)));
    drain();
    chk("tput_in_stalls", nwait, 0);
    chk("tput_out_count", ocnt, 4 * DEG);
    chk("tput_out_span", o_lastc - o_first, 4 * DEG - 1);

    // back-pressure: two rows streaming against a 1,0,0 ready pattern
    rdy_mode = 1; nwait = 0; ocnt = 0;
    for (int i = 0; i < 2 * DEG; i++) send(6'($urandom_range(0, 63)));
    drain();
    chk("bp_in_stall_seen", int'(nwait > 0), 1);
    chk("bp_out_count", ocnt, 2 * DEG);

    // random traffic
    rdy_mode = 2; ocnt = 0;
    for (int i = 0; i < 10 * DEG; i++) begin
      send(6'($urandom_range(0, 63)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    chk("rand_out_count", ocnt, 10 * DEG);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
